// File: rtl/multicycle_ctrl_hs.sv
// Multicycle RV32I control FSM: memory ready handshake, wait timeout,
// illegal-instruction trap, resumable EBREAK halt, cycle/instret counters.
module multicycle_ctrl_hs #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int WAIT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             resume,
  output logic [3:0]       state,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_control,
  output logic [2:0]       imm_src,
  output logic             halted,
  output logic             trapped,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_I    = 4'd3,
    S_EX_S    = 4'd4,
    S_EX_B    = 4'd5,
    S_EX_J    = 4'd6,
    S_MEM_RD  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_WB_ALU  = 4'd9,
    S_WB_MEM  = 4'd10,
    S_WB_LINK = 4'd11,
    S_HALT    = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SRA   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] A_PC   = 2'b00;
  localparam logic [1:0] A_OLD  = 2'b01;
  localparam logic [1:0] A_REG  = 2'b10;
  localparam logic [1:0] B_REG  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_TMO  = 2'b10;

  localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MEM_TIMEOUT);

  state_t            cur;
  state_t            nxt;
  logic [WAIT_W-1:0] wcnt;
  logic [1:0]        cause_q;
  logic [1:0]        trap_code;
  logic              retire;
  logic              timeout;
  logic              mem_pend;
  logic [3:0]        r_alu;
  logic              r_ok;
  logic [3:0]        i_alu;
  logic [3:0]        b_alu;
  logic              b_take;
  logic              b_ok;

  assign mem_pend = (cur == S_IF) || (cur == S_MEM_RD) || (cur == S_MEM_WR);
  assign timeout  = (MEM_TIMEOUT != 0) && (wcnt == TMO) && !mem_ready;

  always_comb begin
    r_alu = ALU_ADD;
    r_ok  = 1'b1;
    unique case ({funct7, funct3})
      {7'h00, 3'd0}: r_alu = ALU_ADD;
      {7'h00, 3'd1}: r_alu = ALU_SLL;
      {7'h00, 3'd2}: r_alu = ALU_SLT;
      {7'h00, 3'd3}: r_alu = ALU_SLTU;
      {7'h00, 3'd4}: r_alu = ALU_XOR;
      {7'h00, 3'd5}: r_alu = ALU_SRL;
      {7'h00, 3'd6}: r_alu = ALU_OR;
      {7'h00, 3'd7}: r_alu = ALU_AND;
      {7'h20, 3'd0}: r_alu = ALU_SUB;
      {7'h20, 3'd5}: r_alu = ALU_SRA;
      default:       r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    i_alu = ALU_ADD;
    unique case (funct3)
      3'd0: i_alu = ALU_ADD;
      3'd1: i_alu = ALU_SLL;
      3'd2: i_alu = ALU_SLT;
      3'd3: i_alu = ALU_SLTU;
      3'd4: i_alu = ALU_XOR;
      3'd5: i_alu = funct7[5] ? ALU_SRA : ALU_SRL;
      3'd6: i_alu = ALU_OR;
      3'd7: i_alu = ALU_AND;
      default: i_alu = ALU_ADD;
    endcase
  end

  // Branch condition: SUB feeds zero for EQ/NE, SLT/SLTU feed !zero for "less".
  always_comb begin
    b_alu  = ALU_ADD;
    b_take = 1'b0;
    b_ok   = 1'b1;
    unique case (funct3)
      3'b000: begin b_alu = ALU_SUB;  b_take = zero;  end
      3'b001: begin b_alu = ALU_SUB;  b_take = !zero; end
      3'b100: begin b_alu = ALU_SLT;  b_take = !zero; end
      3'b101: begin b_alu = ALU_SLT;  b_take = zero;  end
      3'b110: begin b_alu = ALU_SLTU; b_take = !zero; end
      3'b111: begin b_alu = ALU_SLTU; b_take = zero;  end
      default: b_ok = 1'b0;
    endcase
  end

  always_comb begin
    nxt         = cur;
    trap_code   = CAUSE_NONE;
    retire      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = A_PC;
    alu_src_b   = B_REG;
    alu_control = ALU_ADD;
    imm_src     = IMM_I;
    unique case (cur)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_ID;
        end else if (timeout) begin
          nxt       = S_TRAP;
          trap_code = CAUSE_TMO;
        end
      end
      S_ID: begin
        unique case (opcode)
          OP_LOAD, OP_IMM:  nxt = S_EX_I;
          OP_STORE:         nxt = S_EX_S;
          OP_REG:           nxt = S_EX_R;
          OP_BRANCH:        nxt = S_EX_B;
          OP_JAL:           nxt = S_EX_J;
          OP_LUI, OP_AUIPC: nxt = S_WB_ALU;
          OP_SYSTEM: begin
            nxt    = S_HALT;
            retire = 1'b1;
          end
          default: begin
            nxt       = S_TRAP;
            trap_code = CAUSE_ILL;
          end
        endcase
      end
      S_EX_R: begin
        alu_src_a = A_REG;
        alu_src_b = B_REG;
        if (r_ok) begin
          alu_control = r_alu;
          nxt         = S_WB_ALU;
        end else begin
          nxt       = S_TRAP;
          trap_code = CAUSE_ILL;
        end
      end
      S_EX_I: begin
        alu_src_a = A_REG;
        alu_src_b = B_IMM;
        imm_src   = IMM_I;
        if (opcode == OP_LOAD) begin
          alu_control = ALU_ADD;
          nxt         = S_MEM_RD;
        end else begin
          alu_control = i_alu;
          nxt         = S_WB_ALU;
        end
      end
      S_EX_S: begin
        alu_src_a   = A_REG;
        alu_src_b   = B_IMM;
        imm_src     = IMM_S;
        alu_control = ALU_ADD;
        nxt         = S_MEM_WR;
      end
      S_EX_B: begin
        alu_src_a   = A_REG;
        alu_src_b   = B_REG;
        imm_src     = IMM_B;
        pc_src      = 1'b1;
        alu_control = b_alu;
        if (b_ok) begin
          pc_write = b_take;
          retire   = 1'b1;
          nxt      = S_IF;
        end else begin
          nxt       = S_TRAP;
          trap_code = CAUSE_ILL;
        end
      end
      S_EX_J: begin
        alu_src_a   = A_OLD;
        alu_src_b   = B_IMM;
        imm_src     = IMM_J;
        alu_control = ALU_ADD;
        pc_write    = 1'b1;
        nxt         = S_WB_LINK;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          nxt = S_WB_MEM;
        end else if (timeout) begin
          nxt       = S_TRAP;
          trap_code = CAUSE_TMO;
        end
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
          nxt    = S_IF;
        end else if (timeout) begin
          nxt       = S_TRAP;
          trap_code = CAUSE_TMO;
        end
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
        if (opcode == OP_LUI) begin
          alu_src_b   = B_IMM;
          imm_src     = IMM_U;
          alu_control = ALU_PASSB;
        end else if (opcode == OP_AUIPC) begin
          alu_src_a   = A_OLD;
          alu_src_b   = B_IMM;
          imm_src     = IMM_U;
          alu_control = ALU_ADD;
          result_src  = RES_ALU;
        end
        retire = 1'b1;
        nxt    = S_IF;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_src = RES_MDR;
        retire     = 1'b1;
        nxt        = S_IF;
      end
      S_WB_LINK: begin
        alu_src_a   = A_OLD;
        alu_src_b   = B_FOUR;
        alu_control = ALU_ADD;
        reg_write   = 1'b1;
        result_src  = RES_ALU;
        retire      = 1'b1;
        nxt         = S_IF;
      end
      S_HALT: begin
        if (resume) nxt = S_IF;
      end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_IF;
    endcase
  end

  // Wait count only runs while a request is stalled in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur           <= S_IF;
      wcnt          <= '0;
      cause_q       <= CAUSE_NONE;
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      cur         <= nxt;
      cycle_count <= cycle_count + CNT_W'(1);
      if (retire)
        instret_count <= instret_count + CNT_W'(1);
      if (trap_code != CAUSE_NONE)
        cause_q <= trap_code;
      if (mem_pend && !mem_ready && nxt == cur && wcnt != '1)
        wcnt <= wcnt + WAIT_W'(1);
      else if (!(mem_pend && !mem_ready && nxt == cur))
        wcnt <= '0;
    end
  end

  assign state      = cur;
  assign halted     = (cur == S_HALT);
  assign trapped    = (cur == S_TRAP);
  assign trap_cause = cause_q;

endmodule
